// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file write port: A (CPU writeback) has
// priority, B (debug/loader) is guaranteed a slot after MAX_BURST contested A wins.
module regfile_write_arbiter #(
   parameter int DATA_W    = 24,
   parameter int ADDR_W    = 4,
   parameter int MAX_BURST = 4,
   parameter int DROP_R0   = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              AValid,
   input  logic [ADDR_W-1:0] ARD,
   input  logic [DATA_W-1:0] AData,
   output logic              AReady,
   input  logic              BValid,
   input  logic [ADDR_W-1:0] BRD,
   input  logic [DATA_W-1:0] BData,
   output logic              BReady,
   output logic [ADDR_W-1:0] RD,
   output logic [DATA_W-1:0] WriteData,
   output logic              Regwrite,
   output logic              BForced
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   // Handshake: a transfer happens in a cycle where Valid & Ready are both 1.
   // Ready is a pure function of both valids, the burst count and Reset; it
   // never looks at ready. Requesters hold valid/index/data until accepted.
   logic [CNT_W-1:0]  count_q, count_d;
   logic              grant_a, grant_b, forced_b, xfer;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic              regwrite_q, bforced_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] data_q;

   always_comb begin
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      forced_b = 1'b0;
      count_d  = '0;
      if (!Reset) begin
         if (AValid && BValid) begin
            if (count_q == MAX_CNT) begin
               grant_b  = 1'b1;
               forced_b = 1'b1;
            end else begin
               grant_a = 1'b1;
               count_d = count_q + 1'b1;
            end
         end else if (AValid) begin
            grant_a = 1'b1;
         end else if (BValid) begin
            grant_b = 1'b1;
         end
      end
   end

   assign xfer     = grant_a | grant_b;
   assign sel_rd   = grant_a ? ARD : BRD;
   assign sel_data = grant_a ? AData : BData;
   assign AReady   = grant_a;
   assign BReady   = grant_b;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_q    <= '0;
         regwrite_q <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
         bforced_q  <= 1'b0;
      end else begin
         count_q    <= count_d;
         // Writes to register 0 still complete the handshake but are suppressed.
         regwrite_q <= xfer && !((DROP_R0 != 0) && (sel_rd == '0));
         bforced_q  <= forced_b;
         if (xfer) begin
            rd_q   <= sel_rd;
            data_q <= sel_data;
         end
      end
   end

   // Reset during the write cycle cancels the already-registered write.
   assign Regwrite  = regwrite_q & ~Reset;
   assign RD        = rd_q;
   assign WriteData = data_q;
   assign BForced   = bforced_q;

endmodule
